irq_router_mc: RTL and testbench

// Multi-line successor of the dock IRQ router: routes per-slot tile INT channels and NMIs to CPU pins.

---
 rtl/irq_router_mc_pkg.sv | 28 ++
 rtl/irq_router_mc_if.sv | 19 +
 rtl/irq_router_mc_line_arbiter.sv | 90 +++++++++
 rtl/irq_router_mc.sv | 170 +++++++++++++++++
 tb/tb_irq_router_mc.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/irq_router_mc_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : irq_router_pkg
//  Description : Shared types and widths for the multi-line IRQ router.
//  Revision    : 1.0  initial release
// ============================================================================
package irq_router_pkg;

  localparam int PRIO_LEVELS = 4;
  localparam int PRIO_W      = $clog2(PRIO_LEVELS);
  localparam int CPU_W       = 4;
  localparam int ENTRY_W     = 8;

  // One route table entry as written over the cfg bus.
  typedef struct packed {
    logic              en;
    logic              edge_mode;
    logic [PRIO_W-1:0] prio;
    logic [CPU_W-1:0]  cpu;
  } route_entry_t;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } line_state_t;

endpackage
`default_nettype wire

// File: rtl/irq_router_mc_if.sv
`default_nettype none
// ============================================================================
//  Interface   : irq_router_mc_if
//  Description : Dock configuration bus used to program the route table.
//  Revision    : 1.0  initial release
// ============================================================================
interface irq_router_mc_if
  import irq_router_pkg::*;
#(
  parameter int CFG_ADDR_WIDTH = 8
);
  logic                      cfg_wr_en;
  logic [CFG_ADDR_WIDTH-1:0] cfg_addr;
  logic [ENTRY_W-1:0]        cfg_wdata;

  modport master (output cfg_wr_en, output cfg_addr, output cfg_wdata);
  modport slave  (input  cfg_wr_en, input  cfg_addr, input  cfg_wdata);
endinterface
`default_nettype wire

// File: rtl/irq_router_mc_line_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : irq_line_arbiter
//  Description : Per-CPU-INT-line arbiter. Picks the highest-priority eligible
//                source, breaking ties round-robin starting just after the
//                last grant, and holds it until it stops being eligible.
//  Revision    : 1.0  initial release
// ============================================================================
module irq_line_arbiter
  import irq_router_pkg::*;
#(
  parameter int N_SRC = 8,
  parameter int IDX_W = (N_SRC <= 1) ? 1 : $clog2(N_SRC)
)(
  input  wire logic                    clk,
  input  wire logic                    rst,
  input  wire logic                    i_freeze,
  input  wire logic [N_SRC-1:0]        i_elig,
  input  wire logic [N_SRC*PRIO_W-1:0] i_prio,
  input  wire logic                    i_ack,
  output      logic                    o_active,
  output      logic [IDX_W-1:0]        o_grant,
  output      logic                    o_ack_taken
);

  line_state_t       r_state;
  logic [IDX_W-1:0]  r_grant;
  logic [IDX_W-1:0]  r_ptr;

  int                w_rank [N_SRC];
  logic              w_found;
  logic [IDX_W-1:0]  w_best;
  logic [PRIO_W-1:0] w_best_prio;
  int                w_best_rank;

  // Distance of each source from the round-robin start point (wrapping).
  always_comb begin
    for (int i = 0; i < N_SRC; i++) begin
      w_rank[i] = (i >= int'(r_ptr)) ? (i - int'(r_ptr)) : (i + N_SRC - int'(r_ptr));
    end
  end

  // Winner: highest priority first, then smallest round-robin distance.
  always_comb begin
    w_found     = 1'b0;
    w_best      = '0;
    w_best_prio = '0;
    w_best_rank = 0;
    for (int i = 0; i < N_SRC; i++) begin
      if (i_elig[i] && (!w_found || (i_prio[i*PRIO_W +: PRIO_W] > w_best_prio) ||
          ((i_prio[i*PRIO_W +: PRIO_W] == w_best_prio) && (w_rank[i] < w_best_rank)))) begin
        w_found     = 1'b1;
        w_best      = IDX_W'(i);
        w_best_prio = i_prio[i*PRIO_W +: PRIO_W];
        w_best_rank = w_rank[i];
      end
    end
  end

  // Line FSM: grant from IDLE, release once the holder loses eligibility; frozen during NMI.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_grant <= '0;
      r_ptr   <= '0;
    end else if (!i_freeze) begin
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_state <= ACTIVE;
            r_grant <= w_best;
            r_ptr   <= (w_best == IDX_W'(N_SRC - 1)) ? '0 : (w_best + 1'b1);
          end
        end
        ACTIVE: begin
          if (!i_elig[r_grant]) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_active    = (r_state == ACTIVE);
  assign o_grant     = r_grant;
  assign o_ack_taken = i_ack & o_active;

endmodule
`default_nettype wire

// File: rtl/irq_router_mc.sv
`default_nettype none
// ============================================================================
//  Module      : irq_router_mc
//  Description : Routes per-slot tile INT channels and NMIs onto CPU INT/NMI
//                pins. Holds the route table, pending logic, NMI OR tree and
//                the merged slot ack; one arbiter per CPU INT line.
//  Revision    : 1.0  initial release
// ============================================================================
module irq_router_mc
  import irq_router_pkg::*;
#(
  parameter int NUM_SLOTS       = 4,
  parameter int NUM_TILE_INT_CH = 2,
  parameter int NUM_CPU_INT     = 2,
  parameter int NUM_CPU_NMI     = 1,
  parameter int CFG_ADDR_WIDTH  = 8,
  parameter int SLOT_IDX_WIDTH  = (NUM_SLOTS <= 1) ? 1 : $clog2(NUM_SLOTS)
)(
  input  wire logic                                  clk,
  input  wire logic                                  rst,
  input  wire logic [NUM_SLOTS*NUM_TILE_INT_CH-1:0]  i_tile_int_req,
  input  wire logic [NUM_SLOTS-1:0]                  i_tile_nmi_req,
  input  wire logic [NUM_CPU_INT-1:0]                i_irq_ack,
  output      logic [NUM_CPU_INT-1:0]                o_cpu_int,
  output      logic [NUM_CPU_NMI-1:0]                o_cpu_nmi,
  output      logic [NUM_SLOTS-1:0]                  o_slot_ack,
  output      logic [NUM_CPU_INT-1:0]                o_int_active,
  output      logic [NUM_CPU_INT*SLOT_IDX_WIDTH-1:0] o_int_slot,
  irq_router_mc_if.slave                             cfg
);

  localparam int NUM_INT_SRC = NUM_SLOTS * NUM_TILE_INT_CH;
  localparam int NUM_ENTRIES = NUM_INT_SRC + NUM_SLOTS;
  localparam int SRC_IDX_W   = (NUM_INT_SRC <= 1) ? 1 : $clog2(NUM_INT_SRC);

  route_entry_t                r_entry [NUM_ENTRIES];
  logic [NUM_INT_SRC-1:0]      r_req_s;
  logic [NUM_INT_SRC-1:0]      r_req_d;
  logic [NUM_INT_SRC-1:0]      r_pend;
  logic [NUM_SLOTS-1:0]        r_nmi_s;
  logic [NUM_SLOTS-1:0]        r_nmi_pend;
  logic [NUM_SLOTS-1:0]        r_slot_ack;
  logic [NUM_CPU_NMI-1:0]      r_cpu_nmi;

  logic                        w_freeze;
  logic [NUM_INT_SRC*PRIO_W-1:0] w_prio_vec;
  logic [NUM_CPU_INT-1:0]      w_line_active;
  logic [NUM_CPU_INT-1:0]      w_ack_ok;
  logic [SRC_IDX_W-1:0]        w_line_grant [NUM_CPU_INT];
  logic [SLOT_IDX_WIDTH-1:0]   w_line_slot  [NUM_CPU_INT];
  logic [NUM_INT_SRC-1:0]      w_ack_clr;
  logic [NUM_SLOTS-1:0]        w_slot_ack_nxt;
  logic [NUM_CPU_NMI-1:0]      w_cpu_nmi_nxt;

  assign w_freeze = |r_cpu_nmi;

  // Route table writes; addresses past the last entry match nothing.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int e = 0; e < NUM_ENTRIES; e++) r_entry[e] <= '0;
    end else if (cfg.cfg_wr_en) begin
      for (int e = 0; e < NUM_ENTRIES; e++) begin
        if (cfg.cfg_addr == CFG_ADDR_WIDTH'(e)) r_entry[e] <= route_entry_t'(cfg.cfg_wdata);
      end
    end
  end

  // Priority fields flattened for the arbiters.
  always_comb begin
    w_prio_vec = '0;
    for (int i = 0; i < NUM_INT_SRC; i++) w_prio_vec[i*PRIO_W +: PRIO_W] = r_entry[i].prio;
  end

  // Accepted acks clear the granted source's edge pending and pulse its slot.
  always_comb begin
    w_ack_clr      = '0;
    w_slot_ack_nxt = '0;
    for (int l = 0; l < NUM_CPU_INT; l++) begin
      for (int i = 0; i < NUM_INT_SRC; i++) begin
        if (w_ack_ok[l] && (w_line_grant[l] == SRC_IDX_W'(i))) w_ack_clr[i] = 1'b1;
      end
      for (int s = 0; s < NUM_SLOTS; s++) begin
        if (w_ack_ok[l] && (w_line_slot[l] == SLOT_IDX_WIDTH'(s))) w_slot_ack_nxt[s] = 1'b1;
      end
    end
  end

  // Input stage then pending: level follows request, edge latches a rising edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_req_s <= '0;
      r_req_d <= '0;
      r_pend  <= '0;
    end else begin
      r_req_s <= i_tile_int_req;
      r_req_d <= r_req_s;
      for (int i = 0; i < NUM_INT_SRC; i++) begin
        if (!r_entry[i].edge_mode)             r_pend[i] <= r_req_s[i];
        else if (!r_entry[i].en)               r_pend[i] <= 1'b0;
        else if (r_req_s[i] && !r_req_d[i])    r_pend[i] <= 1'b1;
        else if (w_ack_clr[i])                 r_pend[i] <= 1'b0;
      end
    end
  end

  // NMI OR tree over enabled pending NMIs routed to each NMI pin.
  always_comb begin
    w_cpu_nmi_nxt = '0;
    for (int k = 0; k < NUM_CPU_NMI; k++) begin
      for (int s = 0; s < NUM_SLOTS; s++) begin
        if (r_nmi_pend[s] && r_entry[NUM_INT_SRC+s].en &&
            (r_entry[NUM_INT_SRC+s].cpu == CPU_W'(k))) w_cpu_nmi_nxt[k] = 1'b1;
      end
    end
  end

  // NMI pipeline, NMI pins and merged slot ack pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_nmi_s    <= '0;
      r_nmi_pend <= '0;
      r_cpu_nmi  <= '0;
      r_slot_ack <= '0;
    end else begin
      r_nmi_s    <= i_tile_nmi_req;
      r_nmi_pend <= r_nmi_s;
      r_cpu_nmi  <= w_cpu_nmi_nxt;
      r_slot_ack <= w_slot_ack_nxt;
    end
  end

  generate
    for (genvar l = 0; l < NUM_CPU_INT; l++) begin : g_line
      logic [NUM_INT_SRC-1:0] w_elig;

      // A source competes on this line only if pending, enabled and routed here.
      always_comb begin
        for (int i = 0; i < NUM_INT_SRC; i++) begin
          w_elig[i] = r_pend[i] && r_entry[i].en && (r_entry[i].cpu == CPU_W'(l));
        end
      end

      irq_line_arbiter #(
        .N_SRC (NUM_INT_SRC),
        .IDX_W (SRC_IDX_W)
      ) u_arb (
        .clk         (clk),
        .rst         (rst),
        .i_freeze    (w_freeze),
        .i_elig      (w_elig),
        .i_prio      (w_prio_vec),
        .i_ack       (i_irq_ack[l]),
        .o_active    (w_line_active[l]),
        .o_grant     (w_line_grant[l]),
        .o_ack_taken (w_ack_ok[l])
      );

      assign w_line_slot[l] = SLOT_IDX_WIDTH'(w_line_grant[l] / NUM_TILE_INT_CH);
      assign o_int_slot[l*SLOT_IDX_WIDTH +: SLOT_IDX_WIDTH] =
        w_line_active[l] ? w_line_slot[l] : '0;
      assign o_cpu_int[l] = w_line_active[l] & ~w_freeze;
    end
  endgenerate

  assign o_int_active = w_line_active;
  assign o_cpu_nmi    = r_cpu_nmi;
  assign o_slot_ack   = r_slot_ack;

endmodule
`default_nettype wire

// File: tb/tb_irq_router_mc.sv
`default_nettype none
// ============================================================================
//  Module      : tb_irq_router_mc
//  Description : Self-checking bench for irq_router_mc (3 slots, 2 ch,
//                2 INT lines, 1 NMI line) with a cycle-level reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_irq_router_mc;

  localparam int NS = 3;
  localparam int CH = 2;
  localparam int NI = NS * CH;
  localparam int NE = NI + NS;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] req;
  logic [2:0] nmi;
  logic [1:0] ack;
  logic [1:0] cpu_int;
  logic [0:0] cpu_nmi;
  logic [2:0] slot_ack;
  logic [1:0] int_active;
  logic [3:0] int_slot;

  int n_checks = 0;
  int n_err    = 0;

  irq_router_mc_if #(.CFG_ADDR_WIDTH(8)) u_cfg ();

  irq_router_mc #(
    .NUM_SLOTS(NS), .NUM_TILE_INT_CH(CH), .NUM_CPU_INT(2), .NUM_CPU_NMI(1), .CFG_ADDR_WIDTH(8)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .i_tile_int_req (req),
    .i_tile_nmi_req (nmi),
    .i_irq_ack      (ack),
    .o_cpu_int      (cpu_int),
    .o_cpu_nmi      (cpu_nmi),
    .o_slot_ack     (slot_ack),
    .o_int_active   (int_active),
    .o_int_slot     (int_slot),
    .cfg            (u_cfg)
  );

  always #5 clk = ~clk;

  // ---------------- reference model state ----------------
  logic [7:0] m_entry [NE];
  logic [5:0] m_req_s, m_req_d, m_pend;
  logic [2:0] m_nmi_s, m_nmi_pend, m_slot_ack;
  logic       m_cpu_nmi;
  logic [1:0] m_act;
  int         m_gnt [2];
  int         m_ptr [2];

  function automatic bit elig(int i, int l);
    return m_pend[i] && m_entry[i][7] && (int'(m_entry[i][3:0]) == l);
  endfunction

  task automatic model_update();
    logic [5:0] n_pend;
    logic [2:0] n_sack;
    logic       n_nmi;
    logic [1:0] vack;
    bit         acked;
    int         best;
    if (rst) begin
      for (int e = 0; e < NE; e++) m_entry[e] = 8'h00;
      m_req_s = '0; m_req_d = '0; m_pend = '0;
      m_nmi_s = '0; m_nmi_pend = '0; m_slot_ack = '0; m_cpu_nmi = 1'b0;
      m_act = '0;
      for (int l = 0; l < 2; l++) begin m_gnt[l] = 0; m_ptr[l] = 0; end
      return;
    end
    n_sack = '0;
    for (int l = 0; l < 2; l++) begin
      vack[l] = ack[l] && m_act[l];
      if (vack[l]) n_sack[m_gnt[l] / CH] = 1'b1;
    end
    for (int i = 0; i < NI; i++) begin
      acked = 0;
      for (int l = 0; l < 2; l++) if (vack[l] && m_gnt[l] == i) acked = 1;
      if (!m_entry[i][6])                  n_pend[i] = m_req_s[i];
      else if (!m_entry[i][7])             n_pend[i] = 1'b0;
      else if (m_req_s[i] && !m_req_d[i])  n_pend[i] = 1'b1;
      else if (acked)                      n_pend[i] = 1'b0;
      else                                 n_pend[i] = m_pend[i];
    end
    n_nmi = 1'b0;
    for (int s = 0; s < NS; s++)
      if (m_nmi_pend[s] && m_entry[NI+s][7] && m_entry[NI+s][3:0] == 4'd0) n_nmi = 1'b1;
    if (!m_cpu_nmi) begin
      for (int l = 0; l < 2; l++) begin
        if (m_act[l]) begin
          if (!elig(m_gnt[l], l)) m_act[l] = 1'b0;
        end else begin
          best = -1;
          for (int i = 0; i < NI; i++) begin
            if (elig(i, l)) begin
              if (best < 0 || m_entry[i][5:4] > m_entry[best][5:4] ||
                  (m_entry[i][5:4] == m_entry[best][5:4] &&
                   ((i - m_ptr[l] + NI) % NI) < ((best - m_ptr[l] + NI) % NI)))
                best = i;
            end
          end
          if (best >= 0) begin
            m_act[l] = 1'b1;
            m_gnt[l] = best;
            m_ptr[l] = (best + 1) % NI;
          end
        end
      end
    end
    m_pend = n_pend; m_slot_ack = n_sack; m_cpu_nmi = n_nmi;
    m_nmi_pend = m_nmi_s; m_nmi_s = nmi;
    m_req_d = m_req_s; m_req_s = req;
    if (u_cfg.cfg_wr_en && int'(u_cfg.cfg_addr) < NE) m_entry[int'(u_cfg.cfg_addr)] = u_cfg.cfg_wdata;
  endtask

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    logic [1:0] e_int;
    logic [3:0] e_slot;
    for (int l = 0; l < 2; l++) begin
      e_int[l] = m_act[l] && !m_cpu_nmi;
      e_slot[2*l +: 2] = m_act[l] ? 2'(m_gnt[l] / CH) : 2'd0;
    end
    check("cpu_int",    32'(cpu_int),    32'(e_int));
    check("int_active", 32'(int_active), 32'(m_act));
    check("int_slot",   32'(int_slot),   32'(e_slot));
    check("cpu_nmi",    32'(cpu_nmi),    32'(m_cpu_nmi));
    check("slot_ack",   32'(slot_ack),   32'(m_slot_ack));
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    check_outputs();
  endtask

  task automatic steps(int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic wr_cfg(int a, logic [7:0] d);
    u_cfg.cfg_wr_en = 1'b1;
    u_cfg.cfg_addr  = 8'(a);
    u_cfg.cfg_wdata = d;
    step();
    u_cfg.cfg_wr_en = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0; nmi = '0; ack = '0;
    step();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req = '0; nmi = '0; ack = '0;
    u_cfg.cfg_wr_en = 1'b0; u_cfg.cfg_addr = '0; u_cfg.cfg_wdata = '0;
    steps(2);
    check("rst_cpu_int",  32'(cpu_int),  32'd0);
    check("rst_slot_ack", 32'(slot_ack), 32'd0);
    rst = 1'b0;

    // Two lines active at once.
    wr_cfg(0, 8'h80); wr_cfg(2, 8'h81);
    req = 6'b000101;
    steps(3);
    check("s1_cpu_int",  32'(cpu_int),  32'd3);
    check("s1_int_slot", 32'(int_slot), 32'h4);

    // Priority wins, then an idle gap before the lower source is granted.
    do_reset();
    wr_cfg(0, 8'h90); wr_cfg(5, 8'hB0);
    req = 6'b100001;
    steps(3);
    check("s2_slot_hi", 32'(int_slot[1:0]), 32'd2);
    req[5] = 1'b0;
    steps(3);
    check("s2_gap", 32'(cpu_int[0]), 32'd0);
    step();
    check("s2_regrant",  32'(cpu_int[0]),    32'd1);
    check("s2_slot_lo",  32'(int_slot[1:0]), 32'd0);

    // Edge source held until ack, slot ack pulse, then release.
    do_reset();
    wr_cfg(3, 8'hC0);
    req[3] = 1'b1; step(); req[3] = 1'b0;
    steps(2);
    check("s4_held0", 32'(cpu_int[0]), 32'd1);
    steps(3);
    check("s4_held1", 32'(cpu_int[0]), 32'd1);
    ack[0] = 1'b1; step(); ack[0] = 1'b0;
    check("s4_slot_ack", 32'(slot_ack), 32'h2);
    step();
    check("s4_release",  32'(cpu_int[0]), 32'd0);
    check("s4_ack_done", 32'(slot_ack),   32'd0);

    // NMI masks INT, then the held grant reappears.
    do_reset();
    wr_cfg(0, 8'h80);
    req[0] = 1'b1;
    steps(3);
    wr_cfg(8, 8'h80);
    nmi[2] = 1'b1;
    steps(3);
    check("s5_nmi",     32'(cpu_nmi),       32'd1);
    check("s5_masked",  32'(cpu_int),       32'd0);
    check("s5_held",    32'(int_active[0]), 32'd1);
    nmi[2] = 1'b0;
    steps(3);
    check("s5_resume",  32'(cpu_int),       32'd1);
    check("s5_slot",    32'(int_slot[1:0]), 32'd0);

    // Reset mid-operation clears entries.
    rst = 1'b1; step(); rst = 1'b0;
    check("s6_rst_int",  32'(int_active), 32'd0);
    check("s6_rst_slot", 32'(int_slot),   32'd0);
    steps(5);
    check("s6_no_grant", 32'(cpu_int), 32'd0);

    // Randomized traffic against the model.
    for (int cyc = 0; cyc < 2500; cyc++) begin
      logic [7:0] d;
      u_cfg.cfg_wr_en = ($urandom_range(0, 5) == 0);
      u_cfg.cfg_addr  = 8'($urandom_range(0, 10));
      d = 8'($urandom);
      d[7] = ($urandom_range(0, 3) != 0);
      d[3:0] = 4'($urandom_range(0, 2));
      u_cfg.cfg_wdata = d;
      for (int i = 0; i < NI; i++) if ($urandom_range(0, 5) == 0) req[i] = ~req[i];
      for (int s = 0; s < NS; s++) if ($urandom_range(0, 39) == 0) nmi[s] = ~nmi[s];
      ack = 2'($urandom_range(0, 3) & {2{$urandom_range(0, 2) == 0}});
      rst = ($urandom_range(0, 299) == 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
